// File: rtl/pointer_ctrl.sv
// pointer_ctrl: mouse-pointer hit-testing against game boards and a start button,
// with edge-qualified click events for press-release gestures on a single target.
// Ports:
//   clk, rst      clock; synchronous active-high reset
//   en            click enable (hover tracking always runs)
//   x_pos, y_pos  pointer position in pixels
//   left          left mouse button level
//   board_cor     per-board registered hover cell {cx,cy}, all ones when off-board
//   click_valid   one-cycle pulse when a board-cell click completes
//   click_board   board index of the last click
//   click_cor     {cx,cy} of the last click
//   start_pulse   one-cycle pulse when a start-button click completes
module pointer_ctrl #(
    parameter int          NUM_BOARDS = 2,
    parameter logic [11:0] BOARD_X [NUM_BOARDS] = '{12'd100, 12'd538},
    parameter logic [11:0] BOARD_Y = 12'd200,
    parameter int          GRID_N = 10,
    parameter int          CELL_LOG2 = 5,
    parameter logic [11:0] BTN_X = 12'd448,
    parameter logic [11:0] BTN_Y = 12'd40,
    parameter logic [11:0] BTN_W = 12'd128,
    parameter logic [11:0] BTN_H = 12'd64,
    localparam int         CW = $clog2(GRID_N),
    localparam int         BW = NUM_BOARDS > 1 ? $clog2(NUM_BOARDS) : 1
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               en,
    input  logic [11:0]                        x_pos,
    input  logic [11:0]                        y_pos,
    input  logic                               left,
    output logic [NUM_BOARDS-1:0][2*CW-1:0]    board_cor,
    output logic                               click_valid,
    output logic [BW-1:0]                      click_board,
    output logic [2*CW-1:0]                    click_cor,
    output logic                               start_pulse
);
    localparam logic [12:0] SPAN = 13'(GRID_N << CELL_LOG2);

    typedef enum logic [1:0] {IDLE, ARMED, CANCEL} state_t;
    typedef enum logic [1:0] {T_NONE, T_BTN, T_BRD} kind_t;
    typedef struct packed {
        kind_t           kind;
        logic [BW-1:0]   brd;
        logic [2*CW-1:0] cor;
    } tgt_t;

    state_t state_q, state_d;
    tgt_t tgt, armed_q, armed_d;
    logic left_q;
    logic [NUM_BOARDS-1:0][2*CW-1:0] board_cor_q, board_cor_d;
    logic click_valid_q, click_valid_d, start_pulse_q, start_pulse_d;
    logic [BW-1:0] click_board_q, click_board_d;
    logic [2*CW-1:0] click_cor_q, click_cor_d;
    logic [12:0] xe, ye;
    logic y_hit, btn_hit, press, release_e;

    assign xe = {1'b0, x_pos};
    assign ye = {1'b0, y_pos};
    assign y_hit = ye >= {1'b0, BOARD_Y} && ye < {1'b0, BOARD_Y} + SPAN;
    assign btn_hit = xe >= {1'b0, BTN_X} && xe < {1'b0, BTN_X} + {1'b0, BTN_W} &&
                     ye >= {1'b0, BTN_Y} && ye < {1'b0, BTN_Y} + {1'b0, BTN_H};
    assign press = left & ~left_q;
    assign release_e = ~left & left_q;

    // Boards are scanned from the highest index down so the lowest index wins
    // on overlap; the button is applied last so it beats every board.
    always_comb begin
        tgt = '{T_NONE, '0, '0};
        board_cor_d = '1;
        for (int b = NUM_BOARDS - 1; b >= 0; b--) begin
            if (y_hit && xe >= {1'b0, BOARD_X[b]} && xe < {1'b0, BOARD_X[b]} + SPAN) begin
                board_cor_d[b] = {CW'((x_pos - BOARD_X[b]) >> CELL_LOG2),
                                  CW'((y_pos - BOARD_Y) >> CELL_LOG2)};
                tgt = '{T_BRD, BW'(b), board_cor_d[b]};
            end
        end
        if (btn_hit) tgt = '{T_BTN, '0, '0};
    end

    always_comb begin
        state_d = state_q;
        armed_d = armed_q;
        click_valid_d = 1'b0;
        start_pulse_d = 1'b0;
        click_board_d = click_board_q;
        click_cor_d = click_cor_q;
        if (!en) state_d = IDLE;
        else begin
            case (state_q)
                IDLE: if (press) begin
                    state_d = tgt.kind == T_NONE ? CANCEL : ARMED;
                    armed_d = tgt;
                end
                ARMED: if (release_e) begin
                    state_d = IDLE;
                    if (tgt == armed_q) begin
                        start_pulse_d = armed_q.kind == T_BTN;
                        click_valid_d = armed_q.kind == T_BRD;
                        if (armed_q.kind == T_BRD) begin
                            click_board_d = armed_q.brd;
                            click_cor_d = armed_q.cor;
                        end
                    end
                end else if (tgt != armed_q) state_d = CANCEL;
                CANCEL: if (release_e) state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // left_q resets high so a button held through reset never looks like a press.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            armed_q <= '0;
            left_q <= 1'b1;
            board_cor_q <= '1;
            click_valid_q <= 1'b0;
            start_pulse_q <= 1'b0;
            click_board_q <= '0;
            click_cor_q <= '0;
        end else begin
            state_q <= state_d;
            armed_q <= armed_d;
            left_q <= left;
            board_cor_q <= board_cor_d;
            click_valid_q <= click_valid_d;
            start_pulse_q <= start_pulse_d;
            click_board_q <= click_board_d;
            click_cor_q <= click_cor_d;
        end
    end

    assign board_cor = board_cor_q;
    assign click_valid = click_valid_q;
    assign start_pulse = start_pulse_q;
    assign click_board = click_board_q;
    assign click_cor = click_cor_q;
endmodule

// File: tb/tb_pointer_ctrl.sv
// tb_pointer_ctrl: directed and randomized check of pointer_ctrl against a gesture-level model.
module tb_pointer_ctrl;
    logic clk = 1'b0, rst = 1'b1, en = 1'b1, left = 1'b0;
    logic [11:0] x_pos = '0, y_pos = '0;
    logic [1:0][7:0] board_cor;
    logic click_valid, start_pulse;
    logic [0:0] click_board;
    logic [7:0] click_cor;

    pointer_ctrl dut (
        .clk(clk), .rst(rst), .en(en), .x_pos(x_pos), .y_pos(y_pos), .left(left),
        .board_cor(board_cor), .click_valid(click_valid), .click_board(click_board),
        .click_cor(click_cor), .start_pulse(start_pulse)
    );

    always #5 clk = ~clk;

    int n_vec = 0, n_err = 0;
    int bx[2] = '{100, 538};
    int pl, start, exp_v, exp_s, exp_b, exp_c;
    int exp_bc[2];
    bit ok;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int cell_of(input int b, input int x, input int y);
        if (x >= bx[b] && x < bx[b] + 320 && y >= 200 && y < 520)
            return ((x - bx[b]) / 32) * 16 + (y - 200) / 32;
        return 255;
    endfunction

    // Target id: -1 none, 1000 button, else board*256 + cell.
    function automatic int tgt_of(input int x, input int y);
        if (x >= 448 && x < 576 && y >= 40 && y < 104) return 1000;
        for (int b = 0; b < 2; b++)
            if (cell_of(b, x, y) != 255) return b * 256 + cell_of(b, x, y);
        return -1;
    endfunction

    task automatic cyc(input int x, input int y, input int l, input int e);
        int t;
        bit press, rel;
        x_pos = 12'(x);
        y_pos = 12'(y);
        left = l != 0;
        en = e != 0;
        t = tgt_of(x, y);
        press = l != 0 && pl == 0;
        rel = l == 0 && pl != 0;
        exp_v = 0;
        exp_s = 0;
        if (e == 0) ok = 0;
        else if (press) begin
            start = t;
            ok = t != -1;
        end else if (rel) begin
            if (ok && t == start) begin
                if (start == 1000) exp_s = 1;
                else begin
                    exp_v = 1;
                    exp_b = start / 256;
                    exp_c = start % 256;
                end
            end
            ok = 0;
        end else if (l != 0 && t != start) ok = 0;
        pl = l;
        for (int b = 0; b < 2; b++) exp_bc[b] = cell_of(b, x, y);
        @(posedge clk);
        #1;
        chk("board_cor0", board_cor[0], exp_bc[0]);
        chk("board_cor1", board_cor[1], exp_bc[1]);
        chk("click_valid", click_valid, exp_v);
        chk("start_pulse", start_pulse, exp_s);
        chk("click_board", click_board, exp_b);
        chk("click_cor", click_cor, exp_c);
    endtask

    task automatic do_reset(input int x, input int y, input int l);
        rst = 1'b1;
        x_pos = 12'(x);
        y_pos = 12'(y);
        left = l != 0;
        en = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_board_cor", board_cor, 16'hFFFF);
        chk("rst_valid", click_valid, 0);
        chk("rst_start", start_pulse, 0);
        chk("rst_board", click_board, 0);
        chk("rst_cor", click_cor, 0);
        rst = 1'b0;
        pl = 1;
        ok = 0;
        start = -1;
        exp_b = 0;
        exp_c = 0;
    endtask

    initial begin
        int x, y, l, e;
        do_reset(0, 0, 0);
        cyc(100, 200, 0, 1);
        chk("hover_origin0", board_cor[0], 8'h00);
        chk("hover_origin1", board_cor[1], 8'hFF);
        cyc(419, 519, 0, 1);
        chk("hover_corner", board_cor[0], 8'h99);
        cyc(420, 300, 0, 1);
        chk("hover_xedge", board_cor[0], 8'hFF);
        cyc(600, 300, 1, 1);
        cyc(600, 300, 0, 1);
        chk("click_v", click_valid, 1);
        chk("click_b", click_board, 1);
        chk("click_c", click_cor, 8'h13);
        cyc(600, 300, 0, 1);
        chk("click_one_cycle", click_valid, 0);
        cyc(600, 300, 1, 1);
        cyc(640, 300, 1, 1);
        cyc(640, 300, 0, 1);
        chk("drag_none", click_valid, 0);
        cyc(640, 300, 1, 1);
        cyc(640, 300, 0, 1);
        chk("drag_then_click", click_cor, 8'h33);
        cyc(500, 70, 1, 1);
        cyc(500, 70, 0, 1);
        chk("start_click", start_pulse, 1);
        cyc(500, 70, 0, 1);
        chk("start_one_cycle", start_pulse, 0);
        cyc(10, 10, 1, 1);
        cyc(500, 70, 1, 1);
        cyc(500, 70, 0, 1);
        chk("start_from_none", start_pulse, 0);
        do_reset(500, 70, 1);
        cyc(500, 70, 1, 1);
        cyc(500, 70, 0, 1);
        chk("held_reset", start_pulse, 0);
        cyc(500, 70, 1, 1);
        cyc(500, 70, 0, 1);
        chk("after_reset_click", start_pulse, 1);
        cyc(600, 300, 1, 0);
        cyc(600, 300, 0, 0);
        chk("en0_click", click_valid, 0);
        chk("en0_hover", board_cor[1], 8'h13);
        cyc(600, 300, 1, 1);
        cyc(600, 300, 1, 0);
        cyc(600, 300, 1, 1);
        cyc(600, 300, 0, 1);
        chk("en_drop_armed", click_valid, 0);
        x = 600; y = 300; l = 0;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(99) < 25) begin
                case ($urandom_range(3))
                    0: begin x = $urandom_range(585, 440); y = $urandom_range(110, 30); end
                    1: begin x = $urandom_range(430, 90); y = $urandom_range(530, 190); end
                    2: begin x = $urandom_range(870, 530); y = $urandom_range(530, 190); end
                    default: begin x = $urandom_range(1000); y = $urandom_range(700); end
                endcase
            end
            if ($urandom_range(99) < 30) l = l == 0 ? 1 : 0;
            e = $urandom_range(99) < 95 ? 1 : 0;
            if ($urandom_range(999) == 0) do_reset(x, y, l);
            else cyc(x, y, l, e);
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
